// File: rtl/demapper_v2.sv
// demapper_v2: indexes frequency-domain samples per symbol, keeps the configured subcarrier bands
// and forwards them through a two-entry (output + skid) buffer.
module demapper_v2 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FFT_LOG2   = 10,
    parameter int unsigned LO_START   = 1,
    parameter int unsigned LO_END     = 400,
    parameter int unsigned HI_START   = 623,
    parameter int unsigned HI_END     = 1022
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_aresetn,
    input  logic                  s00_axis_tvalid,
    output logic                  s00_axis_tready,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                  s00_axis_tlast,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tlast,
    output logic [FFT_LOG2-1:0]   m00_axis_tuser,
    input  logic                  bypass,
    output logic                  sync_err,
    output logic [15:0]           sym_count
);
    localparam int unsigned N = 1 << FFT_LOG2;

    if (!(LO_START <= LO_END && LO_END < HI_START && HI_START <= HI_END && HI_END <= N - 1))
    begin : g_bad_bounds
        $error("demapper_v2: band bounds must satisfy LO_START<=LO_END<HI_START<=HI_END<=N-1");
    end

    localparam logic [FFT_LOG2-1:0] LO_S     = FFT_LOG2'(LO_START);
    localparam logic [FFT_LOG2-1:0] LO_E     = FFT_LOG2'(LO_END);
    localparam logic [FFT_LOG2-1:0] HI_S     = FFT_LOG2'(HI_START);
    localparam logic [FFT_LOG2-1:0] HI_E     = FFT_LOG2'(HI_END);
    localparam logic [FFT_LOG2-1:0] IDX_LAST = FFT_LOG2'(N - 1);

    logic [FFT_LOG2-1:0]   r_idx;
    logic                  r_mode;
    logic                  r_sync_err;
    logic                  r_s_ready;
    logic [15:0]           r_sym_count;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [FFT_LOG2-1:0]   r_out_user;
    logic                  r_skid_valid;
    logic                  r_skid_last;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [FFT_LOG2-1:0]   r_skid_user;

    logic w_accept;
    logic w_mode;
    logic w_at_end;
    logic w_keep;
    logic w_last;
    logic w_push;
    logic w_pop;
    logic w_skid_valid_d;

    assign w_accept = s00_axis_tvalid && r_s_ready;
    // Mode is sampled from bypass only on the first beat of a symbol.
    assign w_mode   = (r_idx == '0) ? bypass : r_mode;
    assign w_at_end = (r_idx == IDX_LAST);
    assign w_keep   = w_mode || (r_idx >= LO_S && r_idx <= LO_E)
                             || (r_idx >= HI_S && r_idx <= HI_E);
    assign w_last   = s00_axis_tlast || (r_idx == (w_mode ? IDX_LAST : HI_E));
    assign w_push   = w_accept && w_keep;
    assign w_pop    = r_out_valid && m00_axis_tready;

    // Skid holds a beat only while the output register is stalled; it drains on the next pop.
    always_comb begin
        w_skid_valid_d = 1'b0;
        if (r_skid_valid) begin
            w_skid_valid_d = !w_pop;
        end else begin
            w_skid_valid_d = w_push && r_out_valid && !w_pop;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            r_idx        <= '0;
            r_mode       <= 1'b0;
            r_sync_err   <= 1'b0;
            r_s_ready    <= 1'b0;
            r_sym_count  <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_out_user   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_user  <= '0;
        end else begin
            if (w_accept) begin
                r_idx  <= s00_axis_tlast ? '0 : r_idx + 1'b1;
                r_mode <= w_mode;
                if (w_at_end || s00_axis_tlast) begin
                    r_sym_count <= r_sym_count + 16'd1;
                end
            end
            r_sync_err   <= w_accept && s00_axis_tlast && !w_at_end;
            r_skid_valid <= w_skid_valid_d;
            r_s_ready    <= !w_skid_valid_d;
            if (!r_out_valid || w_pop) begin
                r_out_valid <= r_skid_valid || w_push;
                if (r_skid_valid) begin
                    r_out_data <= r_skid_data;
                    r_out_user <= r_skid_user;
                    r_out_last <= r_skid_last;
                end else if (w_push) begin
                    r_out_data <= s00_axis_tdata;
                    r_out_user <= r_idx;
                    r_out_last <= w_last;
                end
            end
            if (w_push && r_out_valid && !w_pop) begin
                r_skid_data <= s00_axis_tdata;
                r_skid_user <= r_idx;
                r_skid_last <= w_last;
            end
        end
    end

    assign s00_axis_tready = r_s_ready;
    assign m00_axis_tvalid = r_out_valid;
    assign m00_axis_tdata  = r_out_data;
    assign m00_axis_tuser  = r_out_user;
    assign m00_axis_tlast  = r_out_last;
    assign sync_err        = r_sync_err;
    assign sym_count       = r_sym_count;
endmodule

// File: tb/tb_demapper_v2.sv
// Directed bench for demapper_v2 with default parameters: band selection, bypass latching,
// early tlast resync, backpressure/stall stability, mid-symbol reset.
module tb_demapper_v2;
    logic        clk = 1'b0;
    logic        rstn;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [9:0]  m_tuser;
    logic        bypass;
    logic        sync_err;
    logic [15:0] sym_count;

    int checks = 0;
    int errors = 0;
    int sync_cnt = 0;
    bit rand_mode = 0;

    int unsigned exp_user[$];
    logic [31:0] exp_data[$];
    bit          exp_last[$];
    int unsigned got_user[$];
    logic [31:0] got_data[$];
    bit          got_last[$];

    int m_idx = 0;
    bit m_mode = 0;

    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic [9:0]  prev_user;
    logic        prev_last;

    demapper_v2 u_dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rstn),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tuser  (m_tuser),
        .bypass          (bypass),
        .sync_err        (sync_err),
        .sym_count       (sym_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            m_tready = 1'($urandom_range(0, 1));
        end
    end

    // Output collector, stall-stability monitor, sync_err pulse counter.
    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'b0, m_tvalid}, 32'd1);
                chk("stall_data", m_tdata, prev_data);
                chk("stall_user", {22'b0, m_tuser}, {22'b0, prev_user});
                chk("stall_last", {31'b0, m_tlast}, {31'b0, prev_last});
            end
            prev_stall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
            prev_data  = m_tdata;
            prev_user  = m_tuser;
            prev_last  = m_tlast;
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                got_user.push_back(m_tuser);
                got_data.push_back(m_tdata);
                got_last.push_back(m_tlast);
            end
            if (sync_err === 1'b1) sync_cnt++;
        end
    end

    // Drive one beat until accepted; update the reference model on acceptance.
    task automatic send(input logic [31:0] d, input bit l);
        int guard = 0;
        bit acc = 0;
        bit keep;
        bit last;
        if (rand_mode) begin
            repeat ($urandom_range(0, 1)) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        do begin
            acc = s_tready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        if (m_idx == 0) m_mode = bypass;
        keep = m_mode || (m_idx >= 1 && m_idx <= 400) || (m_idx >= 623 && m_idx <= 1022);
        last = l || (m_idx == (m_mode ? 1023 : 1022));
        if (keep) begin
            exp_user.push_back(m_idx);
            exp_data.push_back(d);
            exp_last.push_back(last);
        end
        m_idx = l ? 0 : (m_idx + 1) % 1024;
    endtask

    task automatic send_range(input int from, input int to, input bit rnd);
        for (int i = from; i <= to; i++) send(rnd ? $urandom : i, 1'b0);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag);
        int bad = 0;
        chk({tag, "_len"}, got_user.size(), exp_user.size());
        for (int k = 0; k < exp_user.size() && k < got_user.size(); k++) begin
            if (got_user[k] != exp_user[k] || got_data[k] !== exp_data[k] ||
                got_last[k] != exp_last[k]) bad++;
        end
        chk({tag, "_beats_bad"}, bad, 0);
        exp_user.delete(); exp_data.delete(); exp_last.delete();
        got_user.delete(); got_data.delete(); got_last.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        m_tready = 1'b1; bypass = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_tready", {31'b0, s_tready}, 32'd0);
        chk("rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst_sym_count", {16'b0, sym_count}, 32'd0);
        chk("rst_sync_err", {31'b0, sync_err}, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'b0, s_tready}, 32'd1);

        // Three normal symbols, tdata = idx
        send(0, 1'b0);
        send(1, 1'b0);
        chk("latency_valid", {31'b0, m_tvalid}, 32'd1);
        chk("latency_user", {22'b0, m_tuser}, 32'd1);
        chk("latency_data", m_tdata, 32'd1);
        send_range(2, 1023, 1'b0);
        send_range(0, 1023, 1'b0);
        send_range(0, 1023, 1'b0);
        idle(4);
        chk("a_count", got_user.size(), 32'd2400);
        check_stream("a");
        chk("a_sym_count", {16'b0, sym_count}, 32'd3);
        chk("a_sync_cnt", sync_cnt, 32'd0);

        // bypass raised mid-symbol takes effect on the next symbol
        send_range(0, 499, 1'b0);
        bypass = 1'b1;
        send_range(500, 1023, 1'b0);
        send_range(0, 1023, 1'b0);
        bypass = 1'b0;
        idle(4);
        chk("b_count", got_user.size(), 32'd1824);
        chk("b_final_user", got_user[got_user.size() - 1], 32'd1023);
        chk("b_final_last", {31'b0, got_last[got_last.size() - 1]}, 32'd1);
        check_stream("b");
        chk("b_sym_count", {16'b0, sym_count}, 32'd5);

        // Early tlast at idx 700
        send_range(0, 699, 1'b0);
        send(700, 1'b1);
        chk("c_sync_pulse", {31'b0, sync_err}, 32'd1);
        send(0, 1'b0);
        chk("c_sync_one_cycle", {31'b0, sync_err}, 32'd0);
        send_range(1, 10, 1'b0);
        idle(4);
        chk("c_count", got_user.size(), 32'd488);
        chk("c_last_user", got_user[477], 32'd700);
        chk("c_restart_user", got_user[478], 32'd1);
        check_stream("c");
        chk("c_sym_count", {16'b0, sym_count}, 32'd6);
        chk("c_sync_cnt", sync_cnt, 32'd1);

        // tlast exactly at idx 1023
        send_range(11, 1022, 1'b0);
        send(1023, 1'b1);
        idle(4);
        chk("e_count", got_user.size(), 32'd790);
        check_stream("e");
        chk("e_sym_count", {16'b0, sym_count}, 32'd7);
        chk("e_sync_cnt", sync_cnt, 32'd1);

        // Fill both buffer entries, stall, then reset at idx 300
        send_range(0, 298, 1'b0);
        m_tready = 1'b0;
        send(299, 1'b0);
        chk("d_full_s_tready", {31'b0, s_tready}, 32'd0);
        chk("d_full_m_tvalid", {31'b0, m_tvalid}, 32'd1);
        chk("d_full_user", {22'b0, m_tuser}, 32'd298);
        idle(3);
        chk("d_held_user", {22'b0, m_tuser}, 32'd298);
        chk("d_held_s_tready", {31'b0, s_tready}, 32'd0);
        void'(exp_user.pop_back()); void'(exp_data.pop_back()); void'(exp_last.pop_back());
        void'(exp_user.pop_back()); void'(exp_data.pop_back()); void'(exp_last.pop_back());
        check_stream("d_pre");
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("d_rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("d_rst_sym_count", {16'b0, sym_count}, 32'd0);
        chk("d_rst_s_tready", {31'b0, s_tready}, 32'd0);
        rstn = 1'b1;
        m_idx = 0;
        m_mode = 0;
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        send_range(0, 5, 1'b0);
        idle(3);
        chk("d_restart_user", got_user[0], 32'd1);
        check_stream("d_post");

        // Random valid gaps and downstream backpressure, random data
        rand_mode = 1;
        send_range(6, 1023, 1'b1);
        bypass = 1'b1;
        send_range(0, 1023, 1'b1);
        bypass = 1'b0;
        rand_mode = 0;
        idle(1);
        m_tready = 1'b1;
        idle(6);
        chk("r_count", got_user.size(), 32'd1819);
        check_stream("r");
        chk("r_sym_count", {16'b0, sym_count}, 32'd2);
        chk("r_sync_cnt", sync_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
